// File: rtl/pc_if.sv
// Address-path bundle between the control unit and the program counter.
// The control unit drives load/increment requests; the counter drives the fetch address.
interface pc_if #(
  parameter int unsigned WIDTH = 12
);
  logic [WIDTH-1:0] DATA_IN;
  logic             LOAD;
  logic             EN;
  logic [WIDTH-1:0] DATA_OUT;

  modport master (
    output DATA_IN,
    output LOAD,
    output EN,
    input  DATA_OUT
  );

  modport slave (
    input  DATA_IN,
    input  LOAD,
    input  EN,
    output DATA_OUT
  );
endinterface

// File: rtl/pc.sv
// Program counter: async clear, synchronous jump load, and sequential increment.
// The fetch address comes straight from the register, with no logic after it.
module pc #(
  parameter int unsigned          WIDTH       = 12,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic clk,
  input  logic REST,
  pc_if.slave  bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // A jump target overrides any increment issued on the same edge.
  always_comb begin
    count_d = count_q;
    if (bus.LOAD) begin
      count_d = bus.DATA_IN;
    end else if (bus.EN) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge REST) begin
    if (REST) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.DATA_OUT = count_q;

endmodule

// File: tb/tb_pc.sv
// Directed bench for pc: the driver queues expected addresses, and a monitor
// compares them after each rising edge or immediately after an async reset.
module tb_pc;

  localparam int unsigned W = 12;

  typedef struct {
    logic [W-1:0] val;
    string        name;
  } exp_t;

  logic clk;
  logic REST;
  exp_t exp_q[$];
  event chk_ev;
  int   n_checks;
  int   n_pass;

  pc_if #(.WIDTH(W)) bus ();

  pc #(
    .WIDTH       (W),
    .RESET_VALUE (12'h000)
  ) dut (
    .clk  (clk),
    .REST (REST),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: drains the queue after each rising edge or an async-reset trigger.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.DATA_OUT === e.val) begin
          n_pass++;
        end else begin
          $display("FAIL %s: DATA_OUT got %03h, expected %03h", e.name, bus.DATA_OUT, e.val);
        end
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] val, input string name);
    exp_t e;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs on the falling edge; the next rising edge is checked.
  task automatic step(input logic rst, input logic load, input logic en,
                      input logic [W-1:0] din, input logic [W-1:0] expv, input string name);
    @(negedge clk);
    REST        = rst;
    bus.LOAD    = load;
    bus.EN      = en;
    bus.DATA_IN = din;
    push_exp(expv, name);
  endtask

  // Raise REST between edges and check the clear without waiting for a clock.
  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    REST = 1'b1;
    push_exp(12'h000, name);
    ->chk_ev;
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    REST        = 1'b1;
    bus.LOAD    = 1'b0;
    bus.EN      = 1'b0;
    bus.DATA_IN = '0;

    #7;
    push_exp(12'h000, "reset_initial");
    ->chk_ev;
    #1;

    step(1'b0, 1'b1, 1'b0, 12'h5A5, 12'h5A5, "preload_5a5");
    async_reset("async_clear_from_5a5");
    step(1'b1, 1'b1, 1'b1, 12'hABC, 12'h000, "reset_hold_0");
    step(1'b1, 1'b1, 1'b1, 12'hABC, 12'h000, "reset_hold_1");
    step(1'b1, 1'b1, 1'b1, 12'hABC, 12'h000, "reset_hold_2");

    step(1'b0, 1'b1, 1'b0, 12'h006, 12'h006, "load_006");
    step(1'b0, 1'b0, 1'b0, 12'h006, 12'h006, "hold_006_0");
    step(1'b0, 1'b0, 1'b0, 12'h006, 12'h006, "hold_006_1");
    step(1'b0, 1'b0, 1'b0, 12'h006, 12'h006, "hold_006_2");

    step(1'b0, 1'b0, 1'b1, 12'h000, 12'h007, "inc_007");
    step(1'b0, 1'b0, 1'b1, 12'h000, 12'h008, "inc_008");
    step(1'b0, 1'b0, 1'b1, 12'h000, 12'h009, "inc_009");
    step(1'b0, 1'b0, 1'b0, 12'h000, 12'h009, "hold_009_0");
    step(1'b0, 1'b0, 1'b0, 12'h000, 12'h009, "hold_009_1");

    step(1'b0, 1'b1, 1'b0, 12'hFFE, 12'hFFE, "load_ffe");
    step(1'b0, 1'b0, 1'b1, 12'h000, 12'hFFF, "inc_fff");
    step(1'b0, 1'b0, 1'b1, 12'h000, 12'h000, "wrap_000");
    step(1'b0, 1'b0, 1'b1, 12'h000, 12'h001, "wrap_001");

    step(1'b0, 1'b1, 1'b1, 12'h123, 12'h123, "load_beats_inc");
    step(1'b0, 1'b0, 1'b1, 12'h123, 12'h124, "inc_after_load");
    step(1'b0, 1'b0, 1'b0, 12'h3AB, 12'h124, "din_ignored");

    step(1'b0, 1'b1, 1'b0, 12'h010, 12'h010, "load_010");
    step(1'b0, 1'b0, 1'b1, 12'h000, 12'h011, "count_011");
    step(1'b0, 1'b0, 1'b1, 12'h000, 12'h012, "count_012");
    step(1'b0, 1'b0, 1'b1, 12'h000, 12'h013, "count_013");
    async_reset("async_clear_mid_count");
    step(1'b0, 1'b0, 1'b1, 12'h000, 12'h001, "release_inc_001");
    step(1'b0, 1'b0, 1'b1, 12'h000, 12'h002, "release_inc_002");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
